// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector slice: serializer state
// encoding and the default word width used by the detector benches.
package seq_pkg;

  localparam int SEQ_W = 11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Handshake and serial-output bundle of the bit serializer.
// master: the word producer / observer; slave: the serializer itself.
interface seq_bit_serializer_if #(
  parameter int W = seq_pkg::SEQ_W
);
  localparam int LW = $clog2(W + 1);

  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [LW-1:0] in_len;
  logic          in_ready;
  logic          pause;
  logic          dout;
  logic          dout_valid;
  logic          done;
  logic          busy;

  modport master (
    output in_valid, in_data, in_len, pause,
    input  in_ready, dout, dout_valid, done, busy
  );

  modport slave (
    input  in_valid, in_data, in_len, pause,
    output in_ready, dout, dout_valid, done, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage: takes a word plus bit count over valid/ready
// and streams it one bit per clock, gapless across consecutive words.
// pause freezes the stream; done marks the last bit of each word.
// Optional build macro: SER_MSB_FIRST_EN (left-aligned, MSB-first shifting);
// default build is LSB-first.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int W = SEQ_W
) (
  input logic                 clk,
  input logic                 rst,
  seq_bit_serializer_if.slave bus
);
  localparam int            LW      = $clog2(W + 1);
  localparam logic [LW-1:0] W_L     = LW'(W);
  localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] CNT_ZERO = {LW{1'b0}};

  ser_state_t    state_r;
  logic [W-1:0]  sh_r;
  logic [LW-1:0] cnt_r;

  logic [LW-1:0] len_s;
  logic [W-1:0]  load_s;
  logic [W-1:0]  next_sh_s;
  logic          pend_bit_s;
  logic          last_s;
  logic          ready_s;
  logic          accept_s;
  logic          dout_s;
  logic          dout_valid_s;

  // Effective length: 0 or anything above W means a full word.
  always_comb begin
    len_s = W_L;
    if ((bus.in_len == CNT_ZERO) || (bus.in_len > W_L)) begin
      len_s = W_L;
    end else begin
      len_s = bus.in_len;
    end
  end

  // Load image, shifted word and pending bit for the selected bit order.
  always_comb begin
`ifdef SER_MSB_FIRST_EN
    load_s     = bus.in_data << (W_L - len_s);
    next_sh_s  = {sh_r[W-2:0], 1'b0};
    pend_bit_s = sh_r[W-1];
`else
    load_s     = bus.in_data;
    next_sh_s  = {1'b0, sh_r[W-1:1]};
    pend_bit_s = sh_r[0];
`endif
  end

  // Handshake decode; in_ready never looks at in_valid.
  always_comb begin
    last_s = 1'b0;
    if (state_r == SHIFT) begin
      last_s = (!bus.pause) && (cnt_r == CNT_ONE);
    end else begin
      last_s = 1'b0;
    end
    ready_s  = (state_r == IDLE) || last_s;
    accept_s = bus.in_valid && ready_s;
  end

  // Serial output decode; a paused word still shows its pending bit.
  always_comb begin
    dout_s       = 1'b0;
    dout_valid_s = 1'b0;
    if (state_r == SHIFT) begin
      dout_s       = pend_bit_s;
      dout_valid_s = !bus.pause;
    end else begin
      dout_s       = 1'b0;
      dout_valid_s = 1'b0;
    end
  end

  assign bus.in_ready   = ready_s;
  assign bus.dout       = dout_s;
  assign bus.dout_valid = dout_valid_s;
  assign bus.done       = last_s;
  assign bus.busy       = (state_r == SHIFT);

  // Two-state serializer FSM with its word register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sh_r    <= {W{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sh_r    <= load_s;
            cnt_r   <= len_s;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (bus.pause) begin
            state_r <= SHIFT;
          end else if (accept_s) begin
            sh_r    <= load_s;
            cnt_r   <= len_s;
            state_r <= SHIFT;
          end else if (cnt_r == CNT_ONE) begin
            sh_r    <= next_sh_s;
            cnt_r   <= cnt_r - CNT_ONE;
            state_r <= IDLE;
          end else begin
            sh_r    <= next_sh_s;
            cnt_r   <= cnt_r - CNT_ONE;
            state_r <= SHIFT;
          end
        end
        default: begin
          state_r <= IDLE;
          sh_r    <= {W{1'b0}};
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: directed steps plus random
// traffic, compared against a bit-queue model of the serial stream.
module tb_seq_bit_serializer;
  import seq_pkg::*;

  localparam int W  = SEQ_W;
  localparam int LW = $clog2(W + 1);

  logic clk;
  logic rst;

  seq_bit_serializer_if #(.W(W)) ser_if ();

  seq_bit_serializer #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ser_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  bit   q[$];          // expected bits still to appear on dout, in order
  logic accepted;
  logic [63:0] cap;
  int   ncap;
  int   ndone;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Append the bits of a word to the expected stream.
  task automatic push_word(input logic [W-1:0] d, input logic [LW-1:0] l);
    int len;
    len = (l == 0 || int'(l) > W) ? W : int'(l);
`ifdef SER_MSB_FIRST_EN
    for (int i = len - 1; i >= 0; i--) q.push_back(d[i]);
`else
    for (int i = 0; i < len; i++) q.push_back(d[i]);
`endif
  endtask

  // One clock: drive at negedge, check after settling, update model at posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [LW-1:0] l, input logic p);
    logic m_ready, m_valid, m_dout, m_done, m_busy;
    @(negedge clk);
    ser_if.in_valid = v;
    ser_if.in_data  = d;
    ser_if.in_len   = l;
    ser_if.pause    = p;
    #1;
    m_busy  = (q.size() > 0);
    m_valid = m_busy && !p;
    m_ready = (q.size() == 0) || (q.size() == 1 && !p);
    m_dout  = m_busy ? q[0] : 1'b0;
    m_done  = m_valid && (q.size() == 1);
    chk("in_ready",   32'(ser_if.in_ready),   32'(m_ready));
    chk("dout_valid", 32'(ser_if.dout_valid), 32'(m_valid));
    chk("dout",       32'(ser_if.dout),       32'(m_dout));
    chk("done",       32'(ser_if.done),       32'(m_done));
    chk("busy",       32'(ser_if.busy),       32'(m_busy));
    if (ser_if.dout_valid === 1'b1 && ncap < 64) begin
      cap[ncap] = ser_if.dout;
      ncap++;
    end
    if (ser_if.done === 1'b1) ndone++;
    accepted = v && m_ready;
    @(posedge clk);
    if (m_valid) void'(q.pop_front());
    if (accepted) push_word(d, l);
  endtask

  // Offer a word with in_valid held high until the model accepts it.
  task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l);
    accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) step(1'b1, d, l, 1'b0);
    if (!accepted) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  // Idle until the expected stream is empty, then one more idle cycle.
  task automatic drain();
    for (int k = 0; k < 60 && q.size() > 0; k++) step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", q.size());
    end
  endtask

  // Assert reset across one edge with an accept attempt; outputs must idle at once.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ser_if.in_valid = 1'b1;
    ser_if.in_data  = W'($urandom);
    ser_if.in_len   = LW'(W);
    ser_if.pause    = 1'b0;
    #1;
    chk("rst_dout",       32'(ser_if.dout),       32'd0);
    chk("rst_dout_valid", 32'(ser_if.dout_valid), 32'd0);
    chk("rst_done",       32'(ser_if.done),       32'd0);
    chk("rst_busy",       32'(ser_if.busy),       32'd0);
    chk("rst_in_ready",   32'(ser_if.in_ready),   32'd1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    ser_if.in_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ser_if.in_valid = 1'b0;
    ser_if.in_data  = '0;
    ser_if.in_len   = '0;
    ser_if.pause    = 1'b0;
    cap = '0; ncap = 0; ndone = 0;

    do_reset();
    step(1'b0, '0, '0, 1'b1);

`ifdef SER_MSB_FIRST_EN
    // MSB-first word 1101 of length 4 -> 1,1,0,1
    ncap = 0; ndone = 0;
    send(11'b00000001101, 4'd4);
    drain();
    chk("msb_bits", 32'(cap[3:0]), 32'b1011);
    chk("msb_ndone", 32'(ndone), 32'd1);
`else
    // Full 11-bit word, LSB first: 1,0,1,1,1,0,1,1,0,1,1
    ncap = 0; ndone = 0;
    send(11'b11011011101, 4'd11);
    drain();
    chk("w11_count", 32'(ncap), 32'd11);
    chk("w11_bits", 32'(cap[10:0]), 32'b11011011101);
    chk("w11_ndone", 32'(ndone), 32'd1);

    // Back-to-back words 1101/4 and 011/3 -> 1,0,1,1,1,1,0
    ncap = 0; ndone = 0;
    send(11'b00000001101, 4'd4);
    send(11'b00000000011, 4'd3);
    drain();
    chk("b2b_count", 32'(ncap), 32'd7);
    chk("b2b_bits", 32'(cap[6:0]), 32'b0111101);
    chk("b2b_ndone", 32'(ndone), 32'd2);

    // Pause for two cycles after bit 2 of 1011/4
    ncap = 0; ndone = 0;
    send(11'b00000001011, 4'd4);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    drain();
    chk("pause_bits", 32'(cap[3:0]), 32'b1011);
    chk("pause_ndone", 32'(ndone), 32'd1);
`endif

    // Length 0 and 15 both mean a full 11-bit word
    ncap = 0; ndone = 0;
    send(W'($urandom), 4'd0);
    drain();
    chk("len0_count", 32'(ncap), 32'd11);
    ncap = 0;
    send(W'($urandom), 4'd15);
    drain();
    chk("len15_count", 32'(ncap), 32'd11);

    // Reset after bit 5 of an 11-bit word drops it without done
    ncap = 0; ndone = 0;
    send(11'b10101110011, 4'd11);
    repeat (5) step(1'b0, '0, '0, 1'b0);
    do_reset();
    chk("rstmid_bits", 32'(ncap), 32'd5);
    chk("rstmid_ndone", 32'(ndone), 32'd0);
    ncap = 0;
    send(11'b00000010110, 4'd5);
    drain();
    chk("after_rst_count", 32'(ncap), 32'd5);
    chk("after_rst_ndone", 32'(ndone), 32'd1);

    // Random traffic against the stream model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), LW'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial stage feeding the sequence detectors: accepts a word plus bit count over a valid/ready handshake and drives it one bit per clock on a serial output that connects directly to a detector's `din`. The bits of consecutive words stream with no gap. A `pause` input holds the stream, and a `done` pulse marks the final bit of each word.

## Interface
- `W`, 11: maximum word width in bits; minimum value 2.
- `LW`, `$clog2(W+1)`: width of the length field (derived; not overridden).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a word is offered.
- `in_data`  in  W  word to serialize.
- `in_len`  in  LW  number of bits to send, 1..W. Value 0 or greater than W is treated as W.
- `in_ready`  out  1  the stage can accept a word this cycle.
- `pause`  in  1  freeze the stream this cycle.
- `dout`  out  1  serial bit; connects to a detector's `din`.
- `dout_valid`  out  1  `dout` carries a live bit this cycle.
- `done`  out  1  one-cycle pulse on the last bit of a word.
- `busy`  out  1  a word is in flight.

## Operation
- FSM with two states:
  - IDLE → SHIFT on accept, where accept = `in_valid && in_ready`.
  - SHIFT → IDLE when the last bit has been presented and no new word is accepted that cycle.
  - SHIFT → SHIFT when a new word is accepted in the last-bit cycle.
- Word register `sh`, W bits. Bit counter `cnt`, LW bits, holding the number of bits remaining including the current one.
- On accept: load `sh` ← `in_data`, `cnt` ← effective length; state becomes SHIFT.
- In SHIFT with `pause` = 0:
  - `dout` = `sh[0]`.
  - `dout_valid` = 1.
  - Each edge: `sh` ← `sh >> 1`, `cnt` ← `cnt - 1`.
- Last bit is the SHIFT cycle where `cnt == 1` and `pause` = 0. In that cycle `done` = 1.
- `in_ready` = (state == IDLE) or last-bit cycle. This allows gapless back-to-back words.
- `pause` = 1 in SHIFT:
  - `sh`, `cnt` and state hold.
  - `dout_valid` = 0, `done` = 0, `in_ready` = 0.
  - `dout` keeps the pending bit.
- In IDLE: `dout` = 0, `dout_valid` = 0. `pause` has no effect.
- `busy` = (state == SHIFT), including paused cycles.
- `in_data` bits above the effective length are ignored.

## Timing
- Reset (asynchronous): state IDLE, `sh` = 0, `cnt` = 0.
- Output values during and after reset: `dout` = 0, `dout_valid` = 0, `done` = 0, `busy` = 0, `in_ready` = 1.
- Accepts attempted while `rst` = 1 are discarded.
- Latency: first bit of an accepted word appears on `dout` in the cycle after the accept edge.
- A word of length L with no pause occupies exactly L consecutive `dout_valid` cycles.
- Pause cycles extend this one for one.
- Reset asserted mid-word: the word is dropped and no `done` is produced.
- Combinational paths:
  - `in_ready` depends on `pause` and on registered state only, never on `in_valid`.
  - `dout`, `dout_valid` and `done` are decoded from registered state and `pause`.

## Configuration
- `SER_MSB_FIRST_EN`:
  - Defined: on accept, the effective-length field is left-aligned into `sh` (`sh` ← `in_data << (W - len)`). `dout` = `sh[W-1]`, and `sh` shifts left each bit.
  - Undefined (default): LSB-first as described above.
- All handshake and timing rules are identical in both builds.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum `ser_state_t` (IDLE, SHIFT);
  - the default width constant `SEQ_W` = 11, shared with the detector benches.
- Single module; no sub-module is needed.

## Test plan
- Reset, then accept `in_data` = 11'b11011011101 with `in_len` = 11 (LSB-first):
  - `dout` = 1,0,1,1,1,0,1,1,0,1,1 on 11 consecutive cycles starting the cycle after accept.
  - `done` = 1 only on the 11th bit.
  - `in_ready` = 0 on bits 1–10.
- Two words back-to-back: 4'b1101 with `in_len` = 4, then 3'b011 with `in_len` = 3, with `in_valid` held high:
  - `dout` = 1,0,1,1,1,1,0 with no gap.
  - `done` = 1 on bits 4 and 7.
- `pause` high for 2 cycles after bit 2 of 4'b1011 (`in_len` = 4):
  - `dout_valid` drops for 2 cycles.
  - Sequence resumes 1,1,0,1 intact.
  - `busy` stays 1 throughout.
- `in_len` = 0 and `in_len` = 15 (with W = 11): both send 11 bits.
- `rst` pulsed after bit 5 of an 11-bit word:
  - All outputs return to their reset values immediately.
  - No `done` is produced.
  - Next accepted word starts cleanly from its bit 0.
- Build with `SER_MSB_FIRST_EN` defined, `in_data` = 4'b1101, `in_len` = 4: `dout` = 1,1,0,1.
